seg7_scan_mux: RTL and testbench

Time-multiplexed driver for the eight-digit common-anode 7-segment display. It consumes the segment patterns produced by the `vericlock` core: hour, minute and second pairs, plus day, month and the four-digit year. It shows either the time page or the date page, scans one digit at a time with an anti-ghosting blank interval, and blinks selected digits while they are being set. The block sits directly downstream of `vericlock` and drives the board's anode and cathode pins.

---
 rtl/seg7_scan_mux.sv | 184 ++++++++++++++++++
 tb/tb_seg7_scan_mux.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// Eight-digit common-anode 7-segment scan driver for the vericlock time/date pages.
// Frame-coherent snapshot, per-slot anti-ghosting blank interval and digit blinking.
module seg7_scan_mux #(
   parameter int DIGIT_TICKS = 100_000,
   parameter int BLANK_TICKS = 1_000,
   parameter int BLINK_TICKS = 25_000_000
) (
   input  logic        clk_100MHz,
   input  logic        reset,
   input  logic [13:0] hour_7seg,
   input  logic [13:0] min_7seg,
   input  logic [13:0] sec_7seg,
   input  logic [13:0] day_7seg,
   input  logic [13:0] month_7seg,
   input  logic [27:0] year_7seg,
   input  logic        page,
   input  logic [7:0]  blink_mask,
   output logic [7:0]  an_n,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic        frame_start
);

   localparam int TW = $clog2(DIGIT_TICKS);
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [TW-1:0] T_LAST  = TW'(DIGIT_TICKS - 1);
   localparam logic [TW-1:0] T_BLANK = TW'(BLANK_TICKS);
   localparam logic [TW-1:0] T_ONE   = TW'(1);
   localparam logic [TW-1:0] T_ZERO  = TW'(0);
   localparam logic [BW-1:0] B_LAST  = BW'(BLINK_TICKS - 1);
   localparam logic [BW-1:0] B_ONE   = BW'(1);
   localparam logic [BW-1:0] B_ZERO  = BW'(0);

   logic          running_r;
   logic [TW-1:0] t_r;
   logic [2:0]    d_r;
   logic [BW-1:0] blink_cnt_r;
   logic          blink_phase_r;

   logic [13:0]   snap_hour_r;
   logic [13:0]   snap_min_r;
   logic [13:0]   snap_sec_r;
   logic [13:0]   snap_day_r;
   logic [13:0]   snap_month_r;
   logic [27:0]   snap_year_r;
   logic          snap_page_r;
   logic [7:0]    snap_mask_r;

   logic          wrap_s;
   logic          frame_enter_s;
   logic          active_s;
   logic          visible_s;
   logic [6:0]    pat_s;
   logic          dp_s;

   // Slot and frame boundary decode; running_r low means edge 0 has not yet entered (0,0)
   always_comb begin
      wrap_s        = 1'b0;
      frame_enter_s = 1'b0;
      active_s      = 1'b0;
      visible_s     = 1'b1;
      if (running_r) begin
         wrap_s        = (t_r == T_LAST);
         frame_enter_s = wrap_s && (d_r == 3'd7);
         active_s      = (t_r >= T_BLANK);
      end else begin
         frame_enter_s = 1'b1;
      end
      if (snap_mask_r[d_r] && !blink_phase_r) begin
         visible_s = 1'b0;
      end else begin
         visible_s = 1'b1;
      end
   end

   // Digit content selection from the frame snapshot
   always_comb begin
      pat_s = 7'h00;
      dp_s  = 1'b0;
      case ({snap_page_r, d_r})
         4'b0_000: pat_s = snap_sec_r[6:0];
         4'b0_001: pat_s = snap_sec_r[13:7];
         4'b0_010: begin pat_s = snap_min_r[6:0];  dp_s = 1'b1; end
         4'b0_011: pat_s = snap_min_r[13:7];
         4'b0_100: begin pat_s = snap_hour_r[6:0]; dp_s = 1'b1; end
         4'b0_101: pat_s = snap_hour_r[13:7];
         4'b1_000: pat_s = snap_year_r[6:0];
         4'b1_001: pat_s = snap_year_r[13:7];
         4'b1_010: pat_s = snap_year_r[20:14];
         4'b1_011: pat_s = snap_year_r[27:21];
         4'b1_100: begin pat_s = snap_month_r[6:0]; dp_s = 1'b1; end
         4'b1_101: pat_s = snap_month_r[13:7];
         4'b1_110: begin pat_s = snap_day_r[6:0];   dp_s = 1'b1; end
         4'b1_111: pat_s = snap_day_r[13:7];
         default: begin
            pat_s = 7'h00;
            dp_s  = 1'b0;
         end
      endcase
   end

   // Slot counter and digit index
   always_ff @(posedge clk_100MHz or negedge reset) begin
      if (!reset) begin
         running_r <= 1'b0;
         t_r       <= T_ZERO;
         d_r       <= 3'd0;
      end else if (!running_r) begin
         running_r <= 1'b1;
         t_r       <= T_ZERO;
         d_r       <= 3'd0;
      end else if (wrap_s) begin
         t_r <= T_ZERO;
         d_r <= d_r + 3'd1;
      end else begin
         t_r <= t_r + T_ONE;
      end
   end

   // Free-running blink timebase, independent of the scan
   always_ff @(posedge clk_100MHz or negedge reset) begin
      if (!reset) begin
         blink_cnt_r   <= B_ZERO;
         blink_phase_r <= 1'b1;
      end else if (blink_cnt_r == B_LAST) begin
         blink_cnt_r   <= B_ZERO;
         blink_phase_r <= ~blink_phase_r;
      end else begin
         blink_cnt_r <= blink_cnt_r + B_ONE;
      end
   end

   // Frame snapshot, taken on the edge that enters (0,0)
   always_ff @(posedge clk_100MHz or negedge reset) begin
      if (!reset) begin
         snap_hour_r  <= 14'h0000;
         snap_min_r   <= 14'h0000;
         snap_sec_r   <= 14'h0000;
         snap_day_r   <= 14'h0000;
         snap_month_r <= 14'h0000;
         snap_year_r  <= 28'h0000000;
         snap_page_r  <= 1'b0;
         snap_mask_r  <= 8'h00;
      end else if (frame_enter_s) begin
         snap_hour_r  <= hour_7seg;
         snap_min_r   <= min_7seg;
         snap_sec_r   <= sec_7seg;
         snap_day_r   <= day_7seg;
         snap_month_r <= month_7seg;
         snap_year_r  <= year_7seg;
         snap_page_r  <= page;
         snap_mask_r  <= blink_mask;
      end else begin
         snap_page_r  <= snap_page_r;
      end
   end

   // Registered pin drive, one cycle behind the (d,t) state it reflects
   always_ff @(posedge clk_100MHz or negedge reset) begin
      if (!reset) begin
         an_n        <= 8'hFF;
         seg_n       <= 7'h7F;
         dp_n        <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         frame_start <= running_r && (t_r == T_ZERO) && (d_r == 3'd0);
         if (active_s) begin
            an_n <= ~(8'd1 << d_r);
            if (visible_s) begin
               seg_n <= ~pat_s;
               dp_n  <= ~dp_s;
            end else begin
               seg_n <= 7'h7F;
               dp_n  <= 1'b1;
            end
         end else begin
            an_n  <= 8'hFF;
            seg_n <= 7'h7F;
            dp_n  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with DIGIT_TICKS=8, BLANK_TICKS=2, BLINK_TICKS=64.
module tb_seg7_scan_mux;

   logic        clk_100MHz = 1'b0;
   logic        reset = 1'b0;
   logic [13:0] hour_7seg, min_7seg, sec_7seg, day_7seg, month_7seg;
   logic [27:0] year_7seg;
   logic        page;
   logic [7:0]  blink_mask;
   logic [7:0]  an_n;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic        frame_start;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   // Raw patterns per digit, hand-derived from the stimulus below
   logic [6:0] time_pat [8] = '{7'h5B, 7'h06, 7'h66, 7'h4F, 7'h7D, 7'h6D, 7'h00, 7'h00};
   logic       time_dp  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   logic [6:0] date_pat [8] = '{7'h66, 7'h5B, 7'h3F, 7'h5B, 7'h07, 7'h3F, 7'h3F, 7'h06};
   logic       date_dp  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

   seg7_scan_mux #(.DIGIT_TICKS(8), .BLANK_TICKS(2), .BLINK_TICKS(64)) dut (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .hour_7seg  (hour_7seg),
      .min_7seg   (min_7seg),
      .sec_7seg   (sec_7seg),
      .day_7seg   (day_7seg),
      .month_7seg (month_7seg),
      .year_7seg  (year_7seg),
      .page       (page),
      .blink_mask (blink_mask),
      .an_n       (an_n),
      .seg_n      (seg_n),
      .dp_n       (dp_n),
      .frame_start(frame_start)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   // Output cycle n reflects the slot entered on edge n-1
   function automatic int slot_d(int n);
      return ((n - 1) / 8) % 8;
   endfunction
   function automatic int slot_t(int n);
      return (n - 1) % 8;
   endfunction
   function automatic int frame_of(int n);
      return (n - 1) / 64;
   endfunction
   function automatic logic [7:0] exp_an(int n);
      logic [7:0] one;
      one = 8'd1;
      if (n < 1 || slot_t(n) < 2) return 8'hFF;
      return ~(one << slot_d(n));
   endfunction

   task automatic set_inputs(input logic pg, input logic [7:0] mask);
      sec_7seg   = {7'h06, 7'h5B};
      min_7seg   = {7'h4F, 7'h66};
      hour_7seg  = {7'h6D, 7'h7D};
      day_7seg   = {7'h06, 7'h3F};
      month_7seg = {7'h3F, 7'h07};
      year_7seg  = {7'h5B, 7'h3F, 7'h5B, 7'h66};
      page       = pg;
      blink_mask = mask;
   endtask

   task automatic start_run();
      reset = 1'b0;
      @(posedge clk_100MHz);
      @(negedge clk_100MHz);
      reset = 1'b1;
      cyc = -1;
   endtask

   task automatic next_cycle();
      @(posedge clk_100MHz);
      @(negedge clk_100MHz);
      cyc++;
   endtask

   task automatic test_reset();
      set_inputs(1'b0, 8'h00);
      reset = 1'b0;
      repeat (3) @(posedge clk_100MHz);
      @(negedge clk_100MHz);
      tests_run++;
      if (an_n !== 8'hFF) begin tests_failed++; $display("FAIL reset_an got %h want ff", an_n); end
      tests_run++;
      if (seg_n !== 7'h7F) begin tests_failed++; $display("FAIL reset_seg got %h want 7f", seg_n); end
      tests_run++;
      if (dp_n !== 1'b1) begin tests_failed++; $display("FAIL reset_dp got %b want 1", dp_n); end
      tests_run++;
      if (frame_start !== 1'b0) begin tests_failed++; $display("FAIL reset_fs got %b want 0", frame_start); end
      reset = 1'b1;
      cyc = -1;
      for (int i = 0; i < 72; i++) begin
         next_cycle();
         tests_run++;
         if (frame_start !== (cyc == 1 || cyc == 65)) begin
            tests_failed++;
            $display("FAIL frame_start cyc %0d got %b want %b", cyc, frame_start, (cyc == 1 || cyc == 65));
         end
      end
   endtask

   task automatic test_scan_order();
      set_inputs(1'b0, 8'h00);
      start_run();
      for (int i = 0; i < 130; i++) begin
         next_cycle();
         tests_run++;
         if (an_n !== exp_an(cyc)) begin
            tests_failed++;
            $display("FAIL scan_an cyc %0d got %h want %h", cyc, an_n, exp_an(cyc));
         end
         tests_run++;
         if ($countones(~an_n) > 1) begin
            tests_failed++;
            $display("FAIL scan_onehot cyc %0d got %h want at most one low", cyc, an_n);
         end
      end
   endtask

   task automatic test_time_page();
      logic [6:0] es;
      logic       ed;
      set_inputs(1'b0, 8'h00);
      start_run();
      for (int i = 0; i < 65; i++) begin
         next_cycle();
         if (cyc >= 1) begin
            if (slot_t(cyc) >= 2) begin
               es = ~time_pat[slot_d(cyc)];
               ed = ~time_dp[slot_d(cyc)];
            end else begin
               es = 7'h7F;
               ed = 1'b1;
            end
            tests_run++;
            if (seg_n !== es) begin
               tests_failed++;
               $display("FAIL time_seg cyc %0d got %h want %h", cyc, seg_n, es);
            end
            tests_run++;
            if (dp_n !== ed) begin
               tests_failed++;
               $display("FAIL time_dp cyc %0d got %b want %b", cyc, dp_n, ed);
            end
         end
      end
   endtask

   task automatic test_date_page();
      logic [6:0] es;
      logic       ed;
      set_inputs(1'b0, 8'h00);
      start_run();
      for (int i = 0; i < 129; i++) begin
         next_cycle();
         if (cyc >= 1 && slot_t(cyc) >= 2) begin
            if (frame_of(cyc) == 0) begin
               es = ~time_pat[slot_d(cyc)];
               ed = ~time_dp[slot_d(cyc)];
            end else begin
               es = ~date_pat[slot_d(cyc)];
               ed = ~date_dp[slot_d(cyc)];
            end
            tests_run++;
            if (seg_n !== es) begin
               tests_failed++;
               $display("FAIL date_seg cyc %0d got %h want %h", cyc, seg_n, es);
            end
            tests_run++;
            if (dp_n !== ed) begin
               tests_failed++;
               $display("FAIL date_dp cyc %0d got %b want %b", cyc, dp_n, ed);
            end
         end
         if (cyc == 28) page = 1'b1;
      end
   endtask

   task automatic test_blink();
      logic [6:0] es;
      logic       ed;
      set_inputs(1'b0, 8'h03);
      start_run();
      for (int i = 0; i < 193; i++) begin
         next_cycle();
         if (cyc >= 1 && slot_t(cyc) >= 2 && slot_d(cyc) < 3) begin
            if (frame_of(cyc) == 1 && slot_d(cyc) < 2) begin
               es = 7'h7F;
               ed = 1'b1;
            end else begin
               es = ~time_pat[slot_d(cyc)];
               ed = ~time_dp[slot_d(cyc)];
            end
            tests_run++;
            if (seg_n !== es) begin
               tests_failed++;
               $display("FAIL blink_seg cyc %0d got %h want %h", cyc, seg_n, es);
            end
            tests_run++;
            if (dp_n !== ed) begin
               tests_failed++;
               $display("FAIL blink_dp cyc %0d got %b want %b", cyc, dp_n, ed);
            end
            tests_run++;
            if (an_n !== exp_an(cyc)) begin
               tests_failed++;
               $display("FAIL blink_an cyc %0d got %h want %h", cyc, an_n, exp_an(cyc));
            end
         end
      end
   endtask

   task automatic test_async_reset();
      set_inputs(1'b0, 8'h00);
      start_run();
      while (cyc < 44) next_cycle();
      tests_run++;
      if (an_n !== 8'hDF) begin tests_failed++; $display("FAIL pre_reset_an got %h want df", an_n); end
      #1 reset = 1'b0;
      #1;
      tests_run++;
      if (an_n !== 8'hFF) begin tests_failed++; $display("FAIL async_an got %h want ff", an_n); end
      tests_run++;
      if (seg_n !== 7'h7F) begin tests_failed++; $display("FAIL async_seg got %h want 7f", seg_n); end
      tests_run++;
      if (dp_n !== 1'b1) begin tests_failed++; $display("FAIL async_dp got %b want 1", dp_n); end
      @(posedge clk_100MHz);
      @(negedge clk_100MHz);
      reset = 1'b1;
      cyc = -1;
      for (int i = 0; i < 12; i++) begin
         next_cycle();
         tests_run++;
         if (frame_start !== (cyc == 1)) begin
            tests_failed++;
            $display("FAIL restart_fs cyc %0d got %b want %b", cyc, frame_start, (cyc == 1));
         end
         tests_run++;
         if (an_n !== exp_an(cyc)) begin
            tests_failed++;
            $display("FAIL restart_an cyc %0d got %h want %h", cyc, an_n, exp_an(cyc));
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan_order();
      test_time_page();
      test_date_page();
      test_blink();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
